// File: rtl/maria_pkg.sv
// Shared definitions for the Maria display-list fetch path: FSM states,
// header decode fields, HOLEY encodings and the width-to-count helper.
package maria_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PTR  = 3'd2,
    ST_GFX  = 3'd3,
    ST_EMIT = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Header byte 1: low five bits zero mark either end-of-list or an extended header.
  localparam logic [7:0] END_MASK = 8'h1F;
  localparam int         EXT_BIT  = 6;
  localparam int         IND_BIT  = 5;
  localparam int         WM_BIT   = 7;

  localparam logic [1:0] HOLEY_NONE = 2'b00;
  localparam logic [1:0] HOLEY_8    = 2'b01;
  localparam logic [1:0] HOLEY_16   = 2'b10;

  // Width field holds the two's complement of the byte count; zero means 32.
  function automatic logic [5:0] width_to_count(input logic [4:0] width);
    return 6'd32 - {1'b0, width};
  endfunction

endpackage

// File: rtl/maria_holey_check.sv
// Flags graphics addresses that fall into a holey DMA region, where the
// fetch is replaced by a zero byte.
module maria_holey_check
  import maria_pkg::*;
(
  input  logic [15:0] addr_i,
  input  logic [1:0]  holey_i,
  output logic        hole_o
);

  // Hole decode: 8-line holes use A11, 16-line holes use A12, both gated by A15.
  always_comb begin
    hole_o = 1'b0;
    case (holey_i)
      HOLEY_8:  hole_o = addr_i[15] & addr_i[11];
      HOLEY_16: hole_o = addr_i[15] & addr_i[12];
      default:  hole_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/maria_dl_fetch.sv
// Maria display-list walker: parses 4/5-byte object headers for one zone
// line, fetches direct or character-indirect graphics, and streams one
// hpos beat plus graphics beats per object to the line RAM.
module maria_dl_fetch
  import maria_pkg::*;
#(
  parameter int MAX_OBJECTS = 64,
  parameter int ADDR_W      = 16
) (
  input  logic              clk_sys,
  input  logic              RESET_N,
  input  logic              mclk0,
  input  logic              start,
  input  logic              halt,
  input  logic [ADDR_W-1:0] dl_ptr,
  input  logic [3:0]        line_offset,
  input  logic [7:0]        CHARBASE,
  input  logic              CWIDTH,
  input  logic [1:0]        HOLEY,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [7:0]        d_out,
  output logic [2:0]        PALETTE,
  output logic              WM,
  output logic              latch_hpos,
  output logic              latch_byte,
  output logic              busy,
  output logic              done
);

  localparam int OBJ_W = $clog2(MAX_OBJECTS + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   dl_addr_q, dl_addr_d;
  logic [OBJ_W-1:0]    obj_cnt_q, obj_cnt_d;
  logic [2:0]          hdr_idx_q, hdr_idx_d;
  logic                ext_q, ext_d;
  logic                ind_q, ind_d;
  logic [7:0]          addr_lo_q, addr_lo_d;
  logic [7:0]          addr_hi_q, addr_hi_d;
  logic [2:0]          pal_q, pal_d;
  logic [4:0]          width_q, width_d;
  logic                wm_q, wm_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [4:0]          gfx_idx_q, gfx_idx_d;
  logic [7:0]          ptr_q, ptr_d;
  logic                sub_q, sub_d;
  logic [7:0]          dout_q, dout_d;
  logic                beat_hpos_q, beat_hpos_d;

  logic                hdr_done;
  logic                cap_hit;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [ADDR_W-1:0]   ptr_addr;
  logic [ADDR_W-1:0]   gfx_addr;
  logic [7:0]          gfx_hi;
  logic [7:0]          chr_hi;
  logic                gfx_hole;

  // Address generation for header bytes, character pointers and graphics bytes.
  assign cap_hit  = (hdr_idx_q == 3'd0) && (obj_cnt_q == OBJ_W'(MAX_OBJECTS));
  assign hdr_addr = dl_addr_q + {13'd0, hdr_idx_q};
  assign ptr_addr = {addr_hi_q, addr_lo_q} + {11'd0, gfx_idx_q};
  assign gfx_hi   = addr_hi_q + {4'd0, line_offset};
  assign chr_hi   = CHARBASE + {4'd0, line_offset};
  assign gfx_addr = ind_q ? {chr_hi, ptr_q + {7'd0, sub_q}}
                          : ({gfx_hi, addr_lo_q} + {11'd0, gfx_idx_q});

  maria_holey_check u_holey (
    .addr_i  (gfx_addr),
    .holey_i (HOLEY),
    .hole_o  (gfx_hole)
  );

  // State register and all datapath registers.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      dl_addr_q   <= '0;
      obj_cnt_q   <= '0;
      hdr_idx_q   <= '0;
      ext_q       <= 1'b0;
      ind_q       <= 1'b0;
      addr_lo_q   <= '0;
      addr_hi_q   <= '0;
      pal_q       <= '0;
      width_q     <= '0;
      wm_q        <= 1'b0;
      cnt_q       <= '0;
      gfx_idx_q   <= '0;
      ptr_q       <= '0;
      sub_q       <= 1'b0;
      dout_q      <= '0;
      beat_hpos_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_addr_q   <= dl_addr_d;
      obj_cnt_q   <= obj_cnt_d;
      hdr_idx_q   <= hdr_idx_d;
      ext_q       <= ext_d;
      ind_q       <= ind_d;
      addr_lo_q   <= addr_lo_d;
      addr_hi_q   <= addr_hi_d;
      pal_q       <= pal_d;
      width_q     <= width_d;
      wm_q        <= wm_d;
      cnt_q       <= cnt_d;
      gfx_idx_q   <= gfx_idx_d;
      ptr_q       <= ptr_d;
      sub_q       <= sub_d;
      dout_q      <= dout_d;
      beat_hpos_q <= beat_hpos_d;
    end
  end

  // Next-state logic: header parse, pointer/graphics fetch and beat sequencing.
  always_comb begin
    state_d     = state_q;
    dl_addr_d   = dl_addr_q;
    obj_cnt_d   = obj_cnt_q;
    hdr_idx_d   = hdr_idx_q;
    ext_d       = ext_q;
    ind_d       = ind_q;
    addr_lo_d   = addr_lo_q;
    addr_hi_d   = addr_hi_q;
    pal_d       = pal_q;
    width_d     = width_q;
    wm_d        = wm_q;
    cnt_d       = cnt_q;
    gfx_idx_d   = gfx_idx_q;
    ptr_d       = ptr_q;
    sub_d       = sub_q;
    dout_d      = dout_q;
    beat_hpos_d = beat_hpos_q;
    hdr_done    = 1'b0;

    if (halt) begin
      // Halt discards everything in flight, including an ack this cycle.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_HDR;
            dl_addr_d = dl_ptr;
            obj_cnt_d = '0;
            hdr_idx_d = '0;
          end
        end

        ST_HDR: begin
          if (cap_hit) begin
            state_d = ST_DONE;
          end else if (mem_ack) begin
            case (hdr_idx_q)
              3'd0: begin
                addr_lo_d = mem_data;
                hdr_idx_d = 3'd1;
              end
              3'd1: begin
                if ((mem_data & END_MASK) != 8'd0) begin
                  ext_d     = 1'b0;
                  ind_d     = 1'b0;
                  pal_d     = mem_data[7:5];
                  width_d   = mem_data[4:0];
                  hdr_idx_d = 3'd2;
                end else if (!mem_data[EXT_BIT]) begin
                  state_d = ST_DONE;
                end else begin
                  ext_d     = 1'b1;
                  ind_d     = mem_data[IND_BIT];
                  wm_d      = mem_data[WM_BIT];
                  hdr_idx_d = 3'd2;
                end
              end
              3'd2: begin
                addr_hi_d = mem_data;
                hdr_idx_d = 3'd3;
              end
              3'd3: begin
                if (ext_q) begin
                  pal_d     = mem_data[7:5];
                  width_d   = mem_data[4:0];
                  hdr_idx_d = 3'd4;
                end else begin
                  hdr_done = 1'b1;
                end
              end
              default: hdr_done = 1'b1;
            endcase

            // Last header byte is hpos: emit it and arm the per-object counters.
            if (hdr_done) begin
              dout_d      = mem_data;
              beat_hpos_d = 1'b1;
              state_d     = ST_EMIT;
              dl_addr_d   = dl_addr_q + (ext_q ? ADDR_W'(5) : ADDR_W'(4));
              obj_cnt_d   = obj_cnt_q + OBJ_W'(1);
              cnt_d       = width_to_count(width_q);
              gfx_idx_d   = '0;
              sub_d       = 1'b0;
              hdr_idx_d   = '0;
            end
          end
        end

        ST_PTR: begin
          if (mem_ack) begin
            ptr_d   = mem_data;
            sub_d   = 1'b0;
            state_d = ST_GFX;
          end
        end

        ST_GFX: begin
          if (gfx_hole) begin
            dout_d      = 8'h00;
            beat_hpos_d = 1'b0;
            state_d     = ST_EMIT;
          end else if (mem_ack) begin
            dout_d      = mem_data;
            beat_hpos_d = 1'b0;
            state_d     = ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (mclk0) begin
            if (beat_hpos_q) begin
              state_d = ind_q ? ST_PTR : ST_GFX;
            end else if (ind_q && CWIDTH && !sub_q) begin
              sub_d   = 1'b1;
              state_d = ST_GFX;
            end else if (cnt_q == 6'd1) begin
              state_d = ST_HDR;
            end else begin
              cnt_d     = cnt_q - 6'd1;
              gfx_idx_d = gfx_idx_q + 5'd1;
              sub_d     = 1'b0;
              state_d   = ind_q ? ST_PTR : ST_GFX;
            end
          end
        end

        ST_DONE: state_d = ST_IDLE;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the current state; beats are gated by mclk0.
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = '0;
    latch_hpos = 1'b0;
    latch_byte = 1'b0;
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    d_out      = dout_q;
    PALETTE    = pal_q;
    WM         = wm_q;
    case (state_q)
      ST_HDR: begin
        if (!cap_hit) begin
          mem_req  = 1'b1;
          mem_addr = hdr_addr;
        end
      end
      ST_PTR: begin
        mem_req  = 1'b1;
        mem_addr = ptr_addr;
      end
      ST_GFX: begin
        if (!gfx_hole) begin
          mem_req  = 1'b1;
          mem_addr = gfx_addr;
        end
      end
      ST_EMIT: begin
        latch_hpos = mclk0 & beat_hpos_q;
        latch_byte = mclk0 & ~beat_hpos_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/maria_dl_fetch.md
Name: maria_dl_fetch

Overview:
- Display-list walker and graphics-byte DMA engine for one Maria zone line; the write-side producer that feeds the line RAM.
- On `start` it walks the display list at `dl_ptr`, parses 4-byte and 5-byte object headers, and fetches direct or indirect (character) graphics bytes from the shared memory bus.
- Each object is emitted to the line RAM as one `latch_hpos` beat followed by `latch_byte` beats, carrying `PALETTE` and `WM`.

Parameters:
- MAX_OBJECTS, 64: safety cap on headers parsed per line; the walk terminates as end-of-list when it is reached.
- ADDR_W, 16: memory address width.

Ports:
- clk_sys  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- mclk0  in  1  line-RAM write strobe; line-RAM beats are issued only in cycles where mclk0=1
- start  in  1  one-cycle pulse; begin a walk (ignored unless IDLE)
- halt  in  1  abort the walk immediately (end-of-line DMA cutoff)
- dl_ptr  in  16  display list base address for this zone
- line_offset  in  4  zone line offset, added to graphics high byte
- CHARBASE  in  8  character base high byte (indirect mode)
- CWIDTH  in  1  indirect: 1 = two bytes per character pointer
- HOLEY  in  2  00 none, 01 8-line holes (A15&A11), 10 16-line holes (A15&A12), 11 treated as 00
- mem_req  out  1  read request
- mem_addr  out  16  read address, stable while mem_req=1
- mem_ack  in  1  read complete; mem_data valid this cycle
- mem_data  in  8  read data
- d_out  out  8  byte to line RAM (hpos or graphics)
- PALETTE  out  3  palette of the current object
- WM  out  1  sticky write mode
- latch_hpos  out  1  beat: d_out is hpos
- latch_byte  out  1  beat: d_out is graphics
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on end-of-list or MAX_OBJECTS

Behaviour:
Reset values:
- All outputs 0; WM register 0; state IDLE.
- WM is updated only by extended headers and persists across lines and starts.

States: IDLE, HDR, PTR, GFX, EMIT, DONE.

IDLE:
- On start: dl address <= dl_ptr, object count 0, header index 0, go to HDR.

HDR (read header bytes sequentially, one mem_req per byte):
- b0 = addr_lo.
- b1 decides the header format:
  - b1[4:0] != 0: 4-byte header. b1 = {palette[2:0], width[4:0]}, b2 = addr_hi, b3 = hpos.
  - b1[4:0] == 0 and b1[6] == 0: end-of-list. Go to DONE with no further reads.
  - b1[4:0] == 0 and b1[6] == 1: 5-byte extended header. b1 mode = {WM = b1[7], IND = b1[5]}, b2 = addr_hi, b3 = {palette, width}, b4 = hpos.
- Byte count is 32 - width (5-bit wrap). width = 0 in an extended header means 32.
- After the hpos byte: dl address advances by 4 or 5 (16-bit wrap); issue EMIT of hpos (latch_hpos); then go to GFX, or to PTR if IND=1.

Graphics addressing:
- Direct: byte i address = {addr_hi + line_offset (8-bit wrap), addr_lo} + i (16-bit wrap).
- Indirect: PTR reads pointer p at {addr_hi, addr_lo} + i (no offset).
  - GFX then reads {CHARBASE + line_offset, p}.
  - If CWIDTH=1, also reads {…, p + 1} (low byte 8-bit wrap).
  - The width counts pointers, not graphics bytes.
- Holey: if the graphics address matches the HOLEY rule, there is no memory read; EMIT a latch_byte with d_out = 0x00. Pointer reads are never holey.

EMIT:
- Hold d_out, PALETTE and WM.
- Pulse latch_hpos or latch_byte for exactly one cycle, in the first cycle with mclk0=1 (same cycle, if mclk0 is already high).
- Then continue to the next byte. After the last byte of an object, return to HDR.

Memory handshake:
- mem_req asserted with mem_addr stable until the cycle with mem_ack=1.
- mem_req drops the cycle after ack. Minimum 1 idle cycle between requests is not required.
- mem_ack while mem_req=0 is ignored.

DONE:
- Pulse done for 1 cycle, then go to IDLE.
- Object count == MAX_OBJECTS before a header read goes to DONE as well.

halt (priority over all other events):
- Next state IDLE; mem_req, latch_* and busy = 0 next cycle; no done pulse.
- A pending ack is ignored.

Other boundary conditions:
- start while busy: ignored.
- start and halt in the same cycle: halt wins, stays IDLE.
- RESET_N low mid-walk: immediate return to reset values.

Decomposition:
- Shared package maria_pkg:
  - state enum.
  - header decode constants: END_MASK, EXT_BIT = 6, IND_BIT = 5, WM_BIT = 7.
  - HOLEY encodings.
  - function width_to_count(5-bit) -> 6-bit.
- One natural sub-module: maria_holey_check (combinational address + HOLEY -> hole flag), reused by the future DLL fetcher.

Test Plan:
- Direct 4-byte header at 0x1800 = {0x00, 0x5E, 0xA0, 0x10}, then 0x00 0x00 end; line_offset = 2; mem returns 0x55.
  - Expect reads 0x1800..0x1805; latch_hpos d_out = 0x10, PALETTE = 2.
  - Expect 2 latch_byte beats from 0xA200 and 0xA201; then done.
- Extended header {0x40, 0xC0, 0x90, 0x3F, 0x20}, then end, with no prior extended header.
  - Expect WM = 1 and 1 byte from 0x9040.
  - WM stays 1 after done and through the next start.
- Indirect {0x00, 0x60, 0x30, 0x1E, 0x08}, CHARBASE = 0xC0, CWIDTH = 1, line_offset = 1, pointer reads 0x12 and 0xFF.
  - Expect gfx reads 0xC112, 0xC113, 0xC1FF, 0xC100; 4 latch_byte beats.
- HOLEY = 10, direct addr_hi = 0xEF, line_offset = 1 (-> 0xF0, A12 = 1).
  - Expect no gfx mem_req; latch_byte with d_out = 0x00 per byte.
- mclk0 high 1 cycle in 4, mem_ack delayed 3 cycles.
  - Every latch_* is coincident with mclk0 and one cycle wide.
  - mem_addr is constant while mem_req is high.
- halt asserted mid-GFX with mem_req high.
  - Expect IDLE, mem_req = 0 next cycle, no done; a late ack is ignored.
  - A subsequent start walks normally.
